mr_wb_arbiter: RTL and testbench

//  Two-master pipelined Wishbone B4 arbiter that shares the single SoC memory slave between

---
 rtl/mr_wb_arbiter_if.sv | 29 ++
 rtl/mr_wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mr_wb_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mr_wb_arbiter_if.sv
// Pipelined Wishbone B4 request/response bundle used on both sides of the arbiter.
//  master modport: drives adr/dat/we/sel/stb/cyc, receives ack/err/stall
//  slave  modport: receives the request, drives ack/err/stall
//  XLEN sets address/data width; sel is XLEN/8 bits. Read data is not carried here.
interface mr_wb_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned SELW = XLEN / 8;

  logic [XLEN-1:0] adr;
  logic [XLEN-1:0] dat;
  logic            we;
  logic [SELW-1:0] sel;
  logic            stb;
  logic            cyc;
  logic            ack;
  logic            err;
  logic            stall;

  modport master (
    output adr, dat, we, sel, stb, cyc,
    input  ack, err, stall
  );

  modport slave (
    input  adr, dat, we, sel, stb, cyc,
    output ack, err, stall
  );
endinterface

// File: rtl/mr_wb_arbiter.sv
// Two-master pipelined Wishbone B4 arbiter: ifetch (m0) and load-store (m1) share one
// memory slave. One bus tenure per CYC assertion, outstanding strobes capped at
// MAX_OUTST, and m0 gains priority after waiting STARVE_LIMIT cycles (no preemption).
// Ports:
//  clk, rst   system clock, synchronous active-high reset
//  m0, m1     master-side buses (slave modport); non-owner sees stall=1, ack=err=0
//  s          slave-side bus (master modport), request muxed from the owner
//  grant      registered one-hot owner {m1,m0}; 00 = idle
//  timeout    one-cycle pulse on ack watchdog expiry
// Optional feature: define MR_ARB_TIMEOUT_EN to add the ack watchdog (TIMEOUT_CYC);
// without it timeout is tied low and a hung slave stalls the owner indefinitely.
module mr_wb_arbiter #(
  parameter int unsigned MAX_OUTST    = 4,
  parameter int unsigned STARVE_LIMIT = 16,
  parameter int unsigned TIMEOUT_CYC  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  mr_wb_arbiter_if.slave       m0,
  mr_wb_arbiter_if.slave       m1,
  mr_wb_arbiter_if.master      s,
  output logic [1:0]           grant,
  output logic                 timeout
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] outst, outst_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic          prio0, prio0_nxt;
  logic          cap, own_cyc, own_stb, accept, resp_ok, slave_resp;

  assign cap        = (outst == OW'(MAX_OUTST));
  assign slave_resp = s.ack | s.err;
  // Responses with nothing outstanding are stray and must not reach the owner
  assign resp_ok    = slave_resp && (outst != '0);

  // Next-state decode and owner-side request/response routing
  always_comb begin
    state_nxt = state;
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    s.adr     = '0;
    s.dat     = '0;
    s.we      = 1'b0;
    s.sel     = '0;
    s.stb     = 1'b0;
    s.cyc     = 1'b0;
    m0.ack    = 1'b0;
    m0.err    = 1'b0;
    m0.stall  = 1'b1;
    m1.ack    = 1'b0;
    m1.err    = 1'b0;
    m1.stall  = 1'b1;
    case (state)
      IDLE: begin
        if (m0.cyc && m1.cyc) state_nxt = prio0 ? OWN0 : OWN1;
        else if (m1.cyc)      state_nxt = OWN1;
        else if (m0.cyc)      state_nxt = OWN0;
      end
      OWN0: begin
        own_cyc  = m0.cyc;
        own_stb  = m0.stb;
        s.adr    = m0.adr;
        s.dat    = m0.dat;
        s.we     = m0.we;
        s.sel    = m0.sel;
        s.cyc    = m0.cyc;
        s.stb    = m0.stb & ~cap;
        m0.ack   = s.ack & resp_ok & ~timeout;
        m0.err   = (s.err & resp_ok) | timeout;
        m0.stall = s.stall | cap;
        if (!m0.cyc) state_nxt = IDLE;
      end
      OWN1: begin
        own_cyc  = m1.cyc;
        own_stb  = m1.stb;
        s.adr    = m1.adr;
        s.dat    = m1.dat;
        s.we     = m1.we;
        s.sel    = m1.sel;
        s.cyc    = m1.cyc;
        s.stb    = m1.stb & ~cap;
        m1.ack   = s.ack & resp_ok & ~timeout;
        m1.err   = (s.err & resp_ok) | timeout;
        m1.stall = s.stall | cap;
        if (!m1.cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outstanding-strobe tracking and m0 starvation bookkeeping
  always_comb begin
    accept     = own_cyc & own_stb & ~cap & ~s.stall;
    outst_nxt  = outst;
    starve_nxt = '0;
    prio0_nxt  = prio0;
    if (state == IDLE || !own_cyc || timeout) begin
      outst_nxt = '0;
    end else if (accept && !resp_ok) begin
      outst_nxt = outst + OW'(1);
    end else if (!accept && resp_ok) begin
      outst_nxt = outst - OW'(1);
    end
    if (m0.cyc && state != OWN0) begin
      starve_nxt = (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + SW'(1);
    end
    if (state_nxt == OWN0)                    prio0_nxt = 1'b0;
    else if (starve_nxt == SW'(STARVE_LIMIT)) prio0_nxt = 1'b1;
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      outst      <= '0;
      starve_cnt <= '0;
      prio0      <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= {state_nxt == OWN1, state_nxt == OWN0};
      outst      <= outst_nxt;
      starve_cnt <= starve_nxt;
      prio0      <= prio0_nxt;
    end
  end

`ifdef MR_ARB_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);

  logic [WW-1:0] wd_cnt;
  logic          wd_hit;

  // Fires on the TIMEOUT_CYC-th consecutive response-less cycle with work outstanding
  assign wd_hit = (state != IDLE) && own_cyc && (outst != '0) && !slave_resp &&
                  !timeout && (wd_cnt == WW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= wd_hit;
      if (state == IDLE || outst == '0 || slave_resp || timeout || wd_hit) wd_cnt <= '0;
      else                                                                   wd_cnt <= wd_cnt + WW'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mr_wb_arbiter.sv
// Directed self-checking bench for mr_wb_arbiter (default build, MAX_OUTST=4,
// STARVE_LIMIT=16). Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_mr_wb_arbiter;
  logic       clk;
  logic       rst;
  logic [1:0] grant;
  logic       timeout;
  int         errors;
  int         checks;

  mr_wb_arbiter_if #(.XLEN(32)) m0_bus ();
  mr_wb_arbiter_if #(.XLEN(32)) m1_bus ();
  mr_wb_arbiter_if #(.XLEN(32)) s_bus ();

  mr_wb_arbiter #(
    .MAX_OUTST   (4),
    .STARVE_LIMIT(16),
    .TIMEOUT_CYC (255)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .m0     (m0_bus),
    .m1     (m1_bus),
    .s      (s_bus),
    .grant  (grant),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_bus.adr = '0; m0_bus.dat = '0; m0_bus.we = 1'b0; m0_bus.sel = 4'hF;
    m0_bus.stb = 1'b0; m0_bus.cyc = 1'b0;
    m1_bus.adr = '0; m1_bus.dat = '0; m1_bus.we = 1'b0; m1_bus.sel = 4'hF;
    m1_bus.stb = 1'b0; m1_bus.cyc = 1'b0;
    s_bus.ack = 1'b0; s_bus.err = 1'b0; s_bus.stall = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    m1_bus.cyc = 1'b1;
    tick(); tick();
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (s_bus.cyc !== 1'b0) begin errors++; $display("FAIL reset_wbs_cyc: got %b expected 0", s_bus.cyc); end
    checks++; if (s_bus.stb !== 1'b0) begin errors++; $display("FAIL reset_wbs_stb: got %b expected 0", s_bus.stb); end
    checks++; if ({m1_bus.stall, m0_bus.stall} !== 2'b11) begin errors++; $display("FAIL reset_stalls: got %b expected 11", {m1_bus.stall, m0_bus.stall}); end
    checks++; if ({m1_bus.ack, m0_bus.ack, m1_bus.err, m0_bus.err} !== 4'b0000) begin errors++; $display("FAIL reset_ack_err: got %b expected 0000", {m1_bus.ack, m0_bus.ack, m1_bus.err, m0_bus.err}); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    m1_bus.cyc = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1; m1_bus.adr = 32'h0000_1000; m1_bus.sel = 4'hF;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL read_grant_c0: got %b expected 00", grant); end
    checks++; if (m1_bus.stall !== 1'b1) begin errors++; $display("FAIL read_stall_c0: got %b expected 1", m1_bus.stall); end
    tick(); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL read_grant_c1: got %b expected 10", grant); end
    checks++; if (m1_bus.stall !== 1'b0) begin errors++; $display("FAIL read_stall_c1: got %b expected 0", m1_bus.stall); end
    checks++; if ({s_bus.cyc, s_bus.stb} !== 2'b11) begin errors++; $display("FAIL read_wbs_req: got %b expected 11", {s_bus.cyc, s_bus.stb}); end
    checks++; if (s_bus.adr !== 32'h0000_1000) begin errors++; $display("FAIL read_wbs_adr: got %h expected 00001000", s_bus.adr); end
    checks++; if (m0_bus.stall !== 1'b1) begin errors++; $display("FAIL read_m0_stall: got %b expected 1", m0_bus.stall); end
    tick();
    m1_bus.stb = 1'b0; s_bus.ack = 1'b1;
    #1;
    checks++; if ({m1_bus.ack, m0_bus.ack} !== 2'b10) begin errors++; $display("FAIL read_ack: got %b expected 10", {m1_bus.ack, m0_bus.ack}); end
    tick(); #1;
    checks++; if (m1_bus.ack !== 1'b0) begin errors++; $display("FAIL read_stray_ack: got %b expected 0", m1_bus.ack); end
    tick();
    s_bus.ack = 1'b0; m1_bus.cyc = 1'b0;
    #1;
    checks++; if (s_bus.cyc !== 1'b0) begin errors++; $display("FAIL read_cyc_drop: got %b expected 0", s_bus.cyc); end
    tick(); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL read_release: got %b expected 00", grant); end
  endtask

  task automatic test_both_request();
    m0_bus.cyc = 1'b1; m1_bus.cyc = 1'b1;
    tick(); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL both_grant: got %b expected 10", grant); end
    checks++; if ({m1_bus.stall, m0_bus.stall} !== 2'b01) begin errors++; $display("FAIL both_stalls: got %b expected 01", {m1_bus.stall, m0_bus.stall}); end
    tick();
    m1_bus.cyc = 1'b0;
    tick(); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL both_idle_gap: got %b expected 00", grant); end
    tick(); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL both_handoff: got %b expected 01", grant); end
    checks++; if ({m1_bus.stall, m0_bus.stall} !== 2'b10) begin errors++; $display("FAIL both_handoff_stalls: got %b expected 10", {m1_bus.stall, m0_bus.stall}); end
    m0_bus.stb = 1'b1; m0_bus.we = 1'b1; m0_bus.dat = 32'hDEAD_BEEF; m0_bus.sel = 4'h3;
    #1;
    checks++; if ({s_bus.we, s_bus.sel, s_bus.dat} !== {1'b1, 4'h3, 32'hDEAD_BEEF}) begin errors++; $display("FAIL both_write_mux: got %b %h %h expected 1 3 deadbeef", s_bus.we, s_bus.sel, s_bus.dat); end
    tick();
    m0_bus.stb = 1'b0; s_bus.ack = 1'b1;
    #1;
    checks++; if ({m1_bus.ack, m0_bus.ack} !== 2'b01) begin errors++; $display("FAIL both_m0_ack: got %b expected 01", {m1_bus.ack, m0_bus.ack}); end
    tick();
    s_bus.ack = 1'b0; m0_bus.cyc = 1'b0; m0_bus.we = 1'b0; m0_bus.sel = 4'hF;
    tick(); tick();
  endtask

  // m0 waits n cycles behind m1, then both re-request together from IDLE
  task automatic test_starvation(input int n, input logic [1:0] exp_grant, input string tag);
    m1_bus.cyc = 1'b1;
    tick();
    m0_bus.cyc = 1'b1;
    repeat (n) tick();
    m0_bus.cyc = 1'b0; m1_bus.cyc = 1'b0;
    tick(); tick();
    m0_bus.cyc = 1'b1; m1_bus.cyc = 1'b1;
    tick(); #1;
    checks++; if (grant !== exp_grant) begin errors++; $display("FAIL starve_%s: got %b expected %b", tag, grant, exp_grant); end
    m0_bus.cyc = 1'b0; m1_bus.cyc = 1'b0;
    tick(); tick();
  endtask

  task automatic test_outstanding_cap();
    m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1; m0_bus.adr = 32'h0000_0100;
    tick(); #1;
    checks++; if ({m0_bus.stall, s_bus.stb} !== 2'b01) begin errors++; $display("FAIL cap_first: got %b expected 01", {m0_bus.stall, s_bus.stb}); end
    checks++; if (s_bus.adr !== 32'h0000_0100) begin errors++; $display("FAIL cap_adr: got %h expected 00000100", s_bus.adr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      m0_bus.adr = m0_bus.adr + 32'd4;
    end
    #1;
    checks++; if (m0_bus.stall !== 1'b0) begin errors++; $display("FAIL cap_fourth: got %b expected 0", m0_bus.stall); end
    tick(); #1;
    checks++; if ({m0_bus.stall, s_bus.stb} !== 2'b10) begin errors++; $display("FAIL cap_full: got %b expected 10", {m0_bus.stall, s_bus.stb}); end
    tick();
    s_bus.ack = 1'b1;
    #1;
    checks++; if ({m0_bus.ack, m0_bus.stall} !== 2'b11) begin errors++; $display("FAIL cap_ack_while_full: got %b expected 11", {m0_bus.ack, m0_bus.stall}); end
    tick();
    s_bus.ack = 1'b0;
    #1;
    checks++; if ({m0_bus.stall, s_bus.stb} !== 2'b01) begin errors++; $display("FAIL cap_reopen: got %b expected 01", {m0_bus.stall, s_bus.stb}); end
    tick();
    s_bus.ack = 1'b1;
    #1;
    checks++; if (m0_bus.stall !== 1'b1) begin errors++; $display("FAIL cap_refull: got %b expected 1", m0_bus.stall); end
    tick(); #1;
    checks++; if ({m0_bus.ack, m0_bus.stall} !== 2'b10) begin errors++; $display("FAIL cap_accept_and_ack: got %b expected 10", {m0_bus.ack, m0_bus.stall}); end
    tick();
    m0_bus.stb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (m0_bus.ack !== 1'b1) begin errors++; $display("FAIL cap_drain_%0d: got %b expected 1", i, m0_bus.ack); end
      tick();
    end
    #1;
    checks++; if (m0_bus.ack !== 1'b0) begin errors++; $display("FAIL cap_underflow: got %b expected 0", m0_bus.ack); end
    s_bus.ack = 1'b0; m0_bus.cyc = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
    tick(); tick(); tick(); tick();
    m1_bus.stb = 1'b0; rst = 1'b1;
    tick(); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rstmid_grant: got %b expected 00", grant); end
    checks++; if ({s_bus.cyc, m1_bus.stall} !== 2'b01) begin errors++; $display("FAIL rstmid_bus: got %b expected 01", {s_bus.cyc, m1_bus.stall}); end
    rst = 1'b0;
    tick();
    s_bus.ack = 1'b1;
    #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rstmid_regrant: got %b expected 10", grant); end
    checks++; if (m1_bus.ack !== 1'b0) begin errors++; $display("FAIL rstmid_outst_cleared: got %b expected 0", m1_bus.ack); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rstmid_timeout: got %b expected 0", timeout); end
    tick();
    s_bus.ack = 1'b0; m1_bus.cyc = 1'b0;
    tick(); tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_both_request();
    test_starvation(15, 2'b10, "below_limit");
    test_starvation(16, 2'b01, "at_limit");
    test_starvation(0, 2'b10, "prio_cleared");
    test_outstanding_cap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
